// File: rtl/fnd_scan_driver_if.sv
// Bundles the capture-side inputs and scan-side outputs of the FND scan driver.
interface fnd_scan_driver_if #(
    parameter int NUM_DIG = 2
);
    logic                 load;
    logic [8*NUM_DIG-1:0] seg_in;
    logic                 blank_lz;
    logic [7:0]           seg_out;
    logic [NUM_DIG-1:0]   com_n;
    logic                 frame_done;

    modport master (
        output load, seg_in, blank_lz,
        input  seg_out, com_n, frame_done
    );

    modport slave (
        input  load, seg_in, blank_lz,
        output seg_out, com_n, frame_done
    );
endinterface

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed 7-segment scan driver: shadows one pattern per digit and steps a
// shared segment bus plus active-low digit selects through the digits, with dead time.
module fnd_scan_driver #(
    parameter int NUM_DIG  = 2,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fnd_scan_driver_if.slave bus
);
    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam int               IDX_W     = $clog2(NUM_DIG);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD  = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIG - 1);
    localparam logic [7:0]       ZERO_CODE = 8'b11111100;

    logic [8*NUM_DIG-1:0] r_shadow;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           r_seg;
    logic [NUM_DIG-1:0]   r_comN;
    logic                 r_frameDone;

    logic       w_zeroRun;
    logic [7:0] w_digit;
    logic       w_blank;

    // Walk from the top digit down; a digit is a leading zero only while every digit above it is too.
    always_comb begin
        w_zeroRun = 1'b1;
        w_digit   = 8'h00;
        w_blank   = 1'b0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            w_zeroRun = w_zeroRun && (r_shadow[8*k +: 8] == ZERO_CODE);
            if (r_idx == IDX_W'(k)) begin
                w_digit = r_shadow[8*k +: 8];
                w_blank = bus.blank_lz && w_zeroRun && (k != 0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_seg       <= 8'h00;
            r_comN      <= '1;
            r_frameDone <= 1'b0;
        end else begin
            if (bus.load) begin
                r_shadow <= bus.seg_in;
            end

            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            r_frameDone <= (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);

            // Outputs follow the pre-edge cnt/idx/shadow, so a load lands one edge later.
            if (r_cnt < CNT_DEAD) begin
                r_comN <= '1;
                r_seg  <= 8'h00;
            end else begin
                r_comN <= ~(NUM_DIG'(1) << r_idx);
                r_seg  <= w_blank ? 8'h00 : w_digit;
            end
        end
    end

    assign bus.seg_out    = r_seg;
    assign bus.com_n      = r_comN;
    assign bus.frame_done = r_frameDone;
endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver: vector table, hand sequences for blanking,
// mid-slot load and mid-frame reset, then random traffic against a slot-arithmetic model.
module tb_fnd_scan_driver;
    localparam int NUM_DIG  = 2;
    localparam int SCAN_DIV = 8;
    localparam int DEAD     = 2;
    localparam int FRAME    = NUM_DIG * SCAN_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fnd_scan_driver_if #(.NUM_DIG(NUM_DIG)) bus ();

    fnd_scan_driver #(
        .NUM_DIG (NUM_DIG),
        .SCAN_DIV(SCAN_DIV),
        .DEAD    (DEAD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 ld;
        logic [8*NUM_DIG-1:0] seg;
        logic                 blk;
        logic [7:0]           eSeg;
        logic [NUM_DIG-1:0]   eCom;
        logic                 eFd;
    } vec_t;

    vec_t vecs [18];

    int nCompared   = 0;
    int nMismatched = 0;
    int edgeNum     = 0;

    logic [7:0]         mShadow [NUM_DIG];
    logic [7:0]         mSeg;
    logic [NUM_DIG-1:0] mCom;
    logic               mFd;

    task automatic checkOutput(input string name, input logic [7:0] eSeg,
                               input logic [NUM_DIG-1:0] eCom, input logic eFd);
        nCompared++;
        if (bus.seg_out !== eSeg) begin
            nMismatched++;
            $display("[TB] FAIL %s seg_out: got %h, want %h (edge %0d)", name, bus.seg_out, eSeg, edgeNum);
        end
        nCompared++;
        if (bus.com_n !== eCom) begin
            nMismatched++;
            $display("[TB] FAIL %s com_n: got %b, want %b (edge %0d)", name, bus.com_n, eCom, edgeNum);
        end
        nCompared++;
        if (bus.frame_done !== eFd) begin
            nMismatched++;
            $display("[TB] FAIL %s frame_done: got %b, want %b (edge %0d)", name, bus.frame_done, eFd, edgeNum);
        end
    endtask

    // Expected outputs after the upcoming edge, from elapsed edges since reset release.
    task automatic modelOutputs(input logic blk);
        int slotPos;
        int dig;
        bit blanked;
        slotPos = edgeNum % SCAN_DIV;
        dig     = (edgeNum / SCAN_DIV) % NUM_DIG;
        mFd     = ((edgeNum + 1) % FRAME) == 0;
        mCom    = '1;
        mSeg    = 8'h00;
        if (slotPos >= DEAD) begin
            mCom[dig] = 1'b0;
            blanked   = blk && (dig >= 1);
            for (int j = dig; j < NUM_DIG; j++) begin
                if (mShadow[j] != 8'b11111100) blanked = 1'b0;
            end
            mSeg = blanked ? 8'h00 : mShadow[dig];
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [8*NUM_DIG-1:0] seg, input logic blk);
        @(negedge clk);
        bus.load     = ld;
        bus.seg_in   = seg;
        bus.blank_lz = blk;
        @(posedge clk);
        modelOutputs(blk);
        if (ld) begin
            for (int k = 0; k < NUM_DIG; k++) mShadow[k] = seg[8*k +: 8];
        end
        edgeNum++;
        #1;
    endtask

    task automatic runTo(input int target, input logic [8*NUM_DIG-1:0] seg, input logic blk);
        while (edgeNum < target) begin
            applyStimulus(1'b0, seg, blk);
            checkOutput("model", mSeg, mCom, mFd);
        end
    endtask

    // Reset is held with load active and junk data so a capture during reset would show up later.
    task automatic resetDut();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.load     = 1'b1;
        bus.seg_in   = {NUM_DIG{8'h5A}};
        bus.blank_lz = 1'b0;
        #1;
        checkOutput("reset_async", 8'h00, '1, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", 8'h00, '1, 1'b0);
        end
        rst_n    = 1'b1;
        bus.load = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) mShadow[k] = 8'h00;
        edgeNum = 0;
    endtask

    initial begin
        logic [8*NUM_DIG-1:0] rSeg;
        logic                 rLd;
        logic                 rBlk;

        bus.load     = 1'b0;
        bus.seg_in   = '0;
        bus.blank_lz = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) mShadow[k] = 8'h00;

        vecs[0]  = '{1'b1, 16'h60DA, 1'b0, 8'h00, 2'b11, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 2'b11, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 8'hDA, 2'b10, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 8'hDA, 2'b10, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 8'hDA, 2'b10, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 8'hDA, 2'b10, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 8'hDA, 2'b10, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 8'hDA, 2'b10, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 2'b11, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 2'b11, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 8'h60, 2'b01, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 8'h60, 2'b01, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 8'h60, 2'b01, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 8'h60, 2'b01, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 8'h60, 2'b01, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 8'h60, 2'b01, 1'b1};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 8'h00, 2'b11, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 8'h00, 2'b11, 1'b0};

        resetDut();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].seg, vecs[i].blk);
            checkOutput($sformatf("vec%0d", i), vecs[i].eSeg, vecs[i].eCom, vecs[i].eFd);
        end

        resetDut();
        applyStimulus(1'b1, 16'hFCB6, 1'b1);
        runTo(11, 16'hFCB6, 1'b1);
        checkOutput("lz_blank_d1", 8'h00, 2'b01, 1'b0);

        resetDut();
        applyStimulus(1'b1, 16'hFCB6, 1'b0);
        runTo(11, 16'hFCB6, 1'b0);
        checkOutput("lz_off_d1", 8'hFC, 2'b01, 1'b0);

        resetDut();
        applyStimulus(1'b1, 16'hFCFC, 1'b1);
        runTo(3, 16'hFCFC, 1'b1);
        checkOutput("lz_00_d0_kept", 8'hFC, 2'b10, 1'b0);
        runTo(11, 16'hFCFC, 1'b1);
        checkOutput("lz_00_d1_blank", 8'h00, 2'b01, 1'b0);

        resetDut();
        applyStimulus(1'b1, 16'h60DA, 1'b0);
        runTo(5, 16'h60DA, 1'b0);
        checkOutput("mid_pre", 8'hDA, 2'b10, 1'b0);
        applyStimulus(1'b1, 16'h60F2, 1'b0);
        checkOutput("mid_load_edge", 8'hDA, 2'b10, 1'b0);
        applyStimulus(1'b0, 16'h60F2, 1'b0);
        checkOutput("mid_load_next", 8'hF2, 2'b10, 1'b0);
        runTo(11, 16'h60F2, 1'b0);
        checkOutput("mid_d1", 8'h60, 2'b01, 1'b0);
        runTo(16, 16'h60F2, 1'b0);
        checkOutput("mid_frame", 8'h60, 2'b01, 1'b1);
        runTo(28, 16'h60F2, 1'b0);
        checkOutput("pre_reset_d1", 8'h60, 2'b01, 1'b0);

        resetDut();
        applyStimulus(1'b0, 16'h60DA, 1'b0);
        runTo(3, 16'h60DA, 1'b0);
        checkOutput("post_reset_d0", 8'h00, 2'b10, 1'b0);
        runTo(15, 16'h60DA, 1'b0);
        checkOutput("post_reset_e15", 8'h00, 2'b01, 1'b0);
        runTo(16, 16'h60DA, 1'b0);
        checkOutput("post_reset_frame", 8'h00, 2'b01, 1'b1);

        resetDut();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM_DIG; k++) begin
                rSeg[8*k +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFC : 8'($urandom);
            end
            rLd  = ($urandom_range(0, 3) == 0);
            rBlk = 1'($urandom_range(0, 1));
            applyStimulus(rLd, rSeg, rBlk);
            checkOutput("rand", mSeg, mCom, mFd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Time-multiplexed 7-segment (FND) scan driver sitting directly downstream of the BCD-to-FND adder stage. It captures one 8-bit segment pattern per digit, in segment order abcdefg.dp with active-high segments, into a shadow register. It then drives a shared segment bus plus one active-low common-select line per digit, stepping through the digits at a programmable slot rate. Each slot begins with anti-ghosting dead time, and optional leading-zero blanking suppresses high-order zero digits.

## Interface
- NUM_DIG, 2: number of digits scanned (2..8).
- SCAN_DIV, 50000: clock cycles per digit slot (>= 4).
- DEAD, 2: dead-time cycles at the start of each slot (1 <= DEAD < SCAN_DIV).
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture strobe; samples seg_in on the rising edge where load=1.
- seg_in  in  8*NUM_DIG  digit patterns; digit 0 (least significant) in [7:0], digit k in [8k+7:8k].
- blank_lz  in  1  leading-zero blanking enable.
- seg_out  out  8  shared segment bus, active high.
- com_n  out  NUM_DIG  digit common select, active low, at most one bit low at a time.
- frame_done  out  1  one-cycle pulse at the end of each full scan frame.

## Operation
- Reset (async, rst_n=0) values:
  - shadow = all 0; slot counter cnt = 0; digit index idx = 0.
  - seg_out = 8'h00; com_n = all 1; frame_done = 0.
- Shadow register:
  - load=1 at an edge writes shadow <= seg_in.
  - Without load, shadow holds.
  - Patterns are never decoded or validated; 8'h00 and illegal patterns pass through unchanged.
- Slot counter and digit index:
  - cnt counts 0..SCAN_DIV-1 every cycle.
  - At cnt==SCAN_DIV-1: cnt <= 0 and idx <= idx+1, wrapping from NUM_DIG-1 to 0.
- Frame pulse: frame_done is driven 1 for exactly the one cycle following the edge where idx wraps NUM_DIG-1 -> 0.
- Output selection (registered, computed from the current cnt, idx, shadow, blank_lz):
  - cnt < DEAD: com_n = all 1 and seg_out = 8'h00 (dead time).
  - Otherwise: com_n = ~(1 << idx), and seg_out = shadow digit idx, or 8'h00 if that digit is blanked.
- Leading-zero blanking (blank_lz=1):
  - Digit k (k >= 1) is blanked iff its pattern and every higher digit's pattern equal the zero code 8'b11111100.
  - Digit 0 is never blanked.
  - A blanked digit still has its com_n bit asserted low.
  - blank_lz=0 disables all blanking.
- Simultaneous events: load in the same cycle as a slot change or frame wrap — both take effect; the new shadow is used from the next computation.

## Timing
- Outputs are registered, lagging cnt/idx by exactly one clock.
- After rst_n deasserts, the first edge computes from cnt=0, idx=0, so outputs stay inactive for DEAD cycles.
- The first digit-0 drive appears DEAD+1 edges after release.
- Slot length is exactly SCAN_DIV cycles: DEAD inactive cycles, then SCAN_DIV-DEAD drive cycles.
- Frame period is exactly NUM_DIG*SCAN_DIV cycles.
- Load latency: load sampled at edge E updates shadow at E; seg_out reflects the new data at E+1 if the current slot is in drive phase.
- Mid-slot load is permitted and immediately visible; the digit is not restarted.
- Reset mid-operation: all outputs go to their reset values asynchronously; the scan restarts from idx 0 with full dead time.

## Test plan
- Reset check: hold rst_n=0 with arbitrary load/seg_in -> seg_out=8'h00, com_n=2'b11, frame_done=0 every cycle; no capture occurs.
- Basic scan (NUM_DIG=2, SCAN_DIV=8, DEAD=2): load seg_in={8'b01100000, 8'b11011010} ("12").
  - Slot 0: 2 cycles of com_n=11/seg 00, then 6 cycles of com_n=10/seg 11011010.
  - Slot 1: 2 dead cycles, then 6 cycles of com_n=01/seg 01100000.
  - frame_done pulses every 16 cycles.
- Leading-zero blanking: seg_in={8'b11111100, 8'b10110110} ("05"), blank_lz=1.
  - Digit 1 slot shows com_n=01, seg_out=00.
  - Repeat with blank_lz=0 -> seg_out=11111100.
  - "00" with blank_lz=1 -> digit 0 still shows 11111100.
- Mid-slot load: during digit 0 drive phase, pulse load with digit 0 = 8'b11110010 -> seg_out changes on the next edge; cnt/idx sequence is unaffected.
- Reset mid-frame: assert rst_n=0 during digit 1 drive -> outputs clear immediately.
  - On release, shadow is 0, the scan begins at digit 0 after DEAD cycles, and frame_done first pulses 16 cycles later.
